// File: rtl/vx_tex_dcr_arb_if.sv
// DCR write bus between a configuration master and the texture DCR block.
interface VX_dcr_bus_if #(
    parameter int ADDR_BITS = 12,
    parameter int DATA_BITS = 32
);
    logic                 write_valid;
    logic [ADDR_BITS-1:0] write_addr;
    logic [DATA_BITS-1:0] write_data;

    modport master (output write_valid, output write_addr, output write_data);
    modport slave  (input  write_valid, input  write_addr, input  write_data);
endinterface

// File: rtl/vx_tex_dcr_arb.sv
// Round-robin arbiter that funnels per-requester texture DCR writes onto one bus,
// inserting a stage-select write only when the tracked stage differs.
`ifndef VX_DCR_TEX_STAGE
`define VX_DCR_TEX_STAGE  12'h001
`endif
`ifndef VX_DCR_TEX_FORMAT
`define VX_DCR_TEX_FORMAT 12'h004
`endif
`ifndef VX_DCR_TEX_FILTER
`define VX_DCR_TEX_FILTER 12'h005
`endif

module vx_tex_dcr_arb #(
    parameter string INSTANCE_ID = "",
    parameter int    NUM_REQS    = 2,
    parameter int    NUM_STAGES  = 2,
    parameter int    ADDR_BITS   = 12,
    parameter int    DATA_BITS   = 32
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_REQS-1:0]                          req_valid,
    input  logic [NUM_REQS-1:0][$clog2(NUM_STAGES)-1:0]  req_stage,
    input  logic [NUM_REQS-1:0][ADDR_BITS-1:0]           req_addr,
    input  logic [NUM_REQS-1:0][DATA_BITS-1:0]           req_data,
    output logic [NUM_REQS-1:0]                          req_ready,
    input  logic                                         invalidate,
    VX_dcr_bus_if.master                                 dcr_bus_if,
    output logic                                         busy
);
    localparam int STAGE_BITS = $clog2(NUM_STAGES);
    localparam int IDX_BITS   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam logic [ADDR_BITS-1:0] STAGE_ADDR = ADDR_BITS'(`VX_DCR_TEX_STAGE);

    typedef enum logic [1:0] {IDLE, STAGE, DATA} state_t;

    typedef struct packed {
        logic [STAGE_BITS-1:0] stage;
        logic [ADDR_BITS-1:0]  addr;
        logic [DATA_BITS-1:0]  data;
    } req_t;

    state_t                state;
    req_t                  hold;
    logic [STAGE_BITS-1:0] shadow;
    logic                  shadow_valid;
    logic [IDX_BITS-1:0]   rr_ptr;
    logic                  armed;   // low for the first cycle out of reset

    logic                  grant_found;
    logic [IDX_BITS-1:0]   grant_idx;
    req_t                  grant_req;
    logic                  can_accept;
    logic                  accept;
    logic [STAGE_BITS-1:0] eff_shadow;
    logic                  eff_valid;
    logic                  stage_hit;

    // Search starts at rr_ptr and wraps; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr;
        for (int k = 0; k < NUM_REQS; k++) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQS) j = j - NUM_REQS;
            if (!grant_found && req_valid[j]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_BITS'(j);
            end
        end
    end

    always_comb begin
        grant_req.stage = req_stage[grant_idx];
        grant_req.addr  = req_addr[grant_idx];
        grant_req.data  = req_data[grant_idx];
    end

    assign can_accept = armed && !reset && (state == IDLE || state == DATA);

    always_comb begin
        req_ready = '0;
        if (can_accept && grant_found) req_ready[grant_idx] = 1'b1;
    end

    assign accept = |req_ready;

    // Shadow as it stands after this cycle's bus write, so a DATA-cycle accept
    // sees a pass-through stage write or a concurrent invalidate.
    always_comb begin
        eff_shadow = shadow;
        eff_valid  = shadow_valid;
        if (state == DATA && hold.addr == STAGE_ADDR) begin
            eff_shadow = hold.data[STAGE_BITS-1:0];
            eff_valid  = 1'b1;
        end
        if (invalidate) eff_valid = 1'b0;
    end

    assign stage_hit = eff_valid && (eff_shadow == grant_req.stage);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hold         <= '0;
            shadow       <= '0;
            shadow_valid <= 1'b0;
            rr_ptr       <= '0;
            armed        <= 1'b0;
        end else begin
            armed <= 1'b1;

            if (state == STAGE) begin
                shadow       <= hold.stage;
                shadow_valid <= 1'b1;
            end else if (state == DATA && hold.addr == STAGE_ADDR) begin
                shadow       <= hold.data[STAGE_BITS-1:0];
                shadow_valid <= 1'b1;
            end
            if (invalidate) shadow_valid <= 1'b0;

            if (accept) begin
                hold   <= grant_req;
                rr_ptr <= (grant_idx == IDX_BITS'(NUM_REQS - 1)) ? '0
                                                                 : grant_idx + IDX_BITS'(1);
                state  <= stage_hit ? DATA : STAGE;
            end else begin
                case (state)
                    STAGE:   state <= DATA;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        dcr_bus_if.write_valid = 1'b0;
        dcr_bus_if.write_addr  = '0;
        dcr_bus_if.write_data  = '0;
        case (state)
            STAGE: begin
                dcr_bus_if.write_valid = 1'b1;
                dcr_bus_if.write_addr  = STAGE_ADDR;
                dcr_bus_if.write_data  = DATA_BITS'(hold.stage);
            end
            DATA: begin
                dcr_bus_if.write_valid = 1'b1;
                dcr_bus_if.write_addr  = hold.addr;
                dcr_bus_if.write_data  = hold.data;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_vx_tex_dcr_arb.sv
// Directed per-cycle vector table for vx_tex_dcr_arb plus handshake-driven request sequences.
module tb_vx_tex_dcr_arb;
    localparam logic [11:0] STG = 12'h001;
    localparam logic [11:0] FMT = 12'h004;
    localparam logic [11:0] FLT = 12'h005;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0][0:0]  req_stage = '0;
    logic [1:0][11:0] req_addr = '0;
    logic [1:0][31:0] req_data = '0;
    logic [1:0]       req_ready;
    logic             invalidate = 1'b0;
    logic             busy;

    int checks = 0;
    int errors = 0;

    VX_dcr_bus_if #(.ADDR_BITS(12), .DATA_BITS(32)) dcr_bus ();

    vx_tex_dcr_arb #(.NUM_REQS(2), .NUM_STAGES(2), .ADDR_BITS(12), .DATA_BITS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_stage  (req_stage),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .invalidate (invalidate),
        .dcr_bus_if (dcr_bus),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic        s0;
        logic [11:0] a0;
        logic [31:0] d0;
        logic        s1;
        logic [11:0] a1;
        logic [31:0] d1;
        logic        inv;
        logic [1:0]  rdy;
        logic        wv;
        logic [11:0] wa;
        logic [31:0] wd;
        logic        bsy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [1:0] v,
                                input logic s0, input logic [11:0] a0, input logic [31:0] d0,
                                input logic s1, input logic [11:0] a1, input logic [31:0] d1,
                                input logic inv, input logic [1:0] rdy, input logic wv,
                                input logic [11:0] wa, input logic [31:0] wd, input logic bsy);
        vec_t t;
        t.rst = rst; t.v = v; t.s0 = s0; t.a0 = a0; t.d0 = d0;
        t.s1 = s1; t.a1 = a1; t.d1 = d1; t.inv = inv;
        t.rdy = rdy; t.wv = wv; t.wa = wa; t.wd = wd; t.bsy = bsy;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic wv, input logic [11:0] wa,
                             input logic [31:0] wd);
        chk({tag, " write_valid"}, 32'(dcr_bus.write_valid), 32'(wv));
        chk({tag, " write_addr"},  32'(dcr_bus.write_addr),  32'(wa));
        chk({tag, " write_data"},  dcr_bus.write_data,       wd);
    endtask

    // Drive one request and follow it through acceptance and its bus writes.
    task automatic send(input int r, input logic st, input logic [11:0] a,
                        input logic [31:0] d, input bit miss, input string tag);
        bit got;
        got = 1'b0;
        @(negedge clk);
        req_valid = '0;
        req_valid[r] = 1'b1;
        req_stage[r] = st;
        req_addr[r]  = a;
        req_data[r]  = d;
        for (int n = 0; n < 8; n++) begin
            #1;
            if (req_ready[r]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, " accepted"}, 32'(got), 32'd1);
        @(negedge clk);
        req_valid = '0;
        #1;
        if (miss) begin
            check_bus({tag, " stage"}, 1'b1, STG, 32'(st));
            @(negedge clk);
            #1;
        end
        check_bus({tag, " data"}, 1'b1, a, d);
    endtask

    initial begin
        // rst v  s0 a0  d0      s1 a1  d1      inv rdy  wv wa   wd      busy
        tbl.push_back(mk(1, 2'b11, 1, FMT, 32'h3,  0, FLT, 32'h9,  0, 2'b00, 0, 0,   0,      0));
        tbl.push_back(mk(1, 2'b11, 1, FMT, 32'h3,  0, FLT, 32'h9,  0, 2'b00, 0, 0,   0,      0));
        tbl.push_back(mk(0, 2'b01, 1, FMT, 32'h3,  0, 0,   0,      0, 2'b00, 0, 0,   0,      0));
        tbl.push_back(mk(0, 2'b01, 1, FMT, 32'h3,  0, 0,   0,      0, 2'b01, 0, 0,   0,      0));
        tbl.push_back(mk(0, 2'b00, 0, 0,   0,      0, 0,   0,      0, 2'b00, 1, STG, 32'h1,  1));
        tbl.push_back(mk(0, 2'b00, 0, 0,   0,      0, 0,   0,      0, 2'b00, 1, FMT, 32'h3,  1));
        tbl.push_back(mk(0, 2'b01, 1, FLT, 32'h1,  0, 0,   0,      0, 2'b01, 0, 0,   0,      0));
        tbl.push_back(mk(0, 2'b00, 0, 0,   0,      0, 0,   0,      0, 2'b00, 1, FLT, 32'h1,  1));
        tbl.push_back(mk(0, 2'b00, 0, 0,   0,      0, 0,   0,      0, 2'b00, 0, 0,   0,      0));
        // same-stage stream of four: back-to-back data writes
        tbl.push_back(mk(0, 2'b01, 1, FMT, 32'hA,  0, 0,   0,      0, 2'b01, 0, 0,   0,      0));
        tbl.push_back(mk(0, 2'b01, 1, FLT, 32'hB,  0, 0,   0,      0, 2'b01, 1, FMT, 32'hA,  1));
        tbl.push_back(mk(0, 2'b01, 1, FMT, 32'hC,  0, 0,   0,      0, 2'b01, 1, FLT, 32'hB,  1));
        tbl.push_back(mk(0, 2'b01, 1, FLT, 32'hD,  0, 0,   0,      0, 2'b01, 1, FMT, 32'hC,  1));
        tbl.push_back(mk(0, 2'b00, 0, 0,   0,      0, 0,   0,      0, 2'b00, 1, FLT, 32'hD,  1));
        // alternating stages: stage write before each data write
        tbl.push_back(mk(0, 2'b01, 0, FMT, 32'h10, 0, 0,   0,      0, 2'b01, 0, 0,   0,      0));
        tbl.push_back(mk(0, 2'b01, 1, FMT, 32'h11, 0, 0,   0,      0, 2'b00, 1, STG, 32'h0,  1));
        tbl.push_back(mk(0, 2'b01, 1, FMT, 32'h11, 0, 0,   0,      0, 2'b01, 1, FMT, 32'h10, 1));
        tbl.push_back(mk(0, 2'b00, 0, 0,   0,      0, 0,   0,      0, 2'b00, 1, STG, 32'h1,  1));
        tbl.push_back(mk(0, 2'b00, 0, 0,   0,      0, 0,   0,      0, 2'b00, 1, FMT, 32'h11, 1));
        // pass-through stage write retargets the shadow for a same-cycle accept
        tbl.push_back(mk(0, 2'b01, 1, STG, 32'h0,  0, 0,   0,      0, 2'b01, 0, 0,   0,      0));
        tbl.push_back(mk(0, 2'b01, 0, FMT, 32'h20, 0, 0,   0,      0, 2'b01, 1, STG, 32'h0,  1));
        tbl.push_back(mk(0, 2'b00, 0, 0,   0,      0, 0,   0,      0, 2'b00, 1, FMT, 32'h20, 1));
        // round robin with both requesters valid
        tbl.push_back(mk(0, 2'b10, 0, 0,   0,      0, FMT, 32'h30, 0, 2'b10, 0, 0,   0,      0));
        tbl.push_back(mk(0, 2'b11, 0, FLT, 32'h40, 0, FLT, 32'h41, 0, 2'b01, 1, FMT, 32'h30, 1));
        tbl.push_back(mk(0, 2'b11, 0, FMT, 32'h42, 0, FLT, 32'h41, 0, 2'b10, 1, FLT, 32'h40, 1));
        tbl.push_back(mk(0, 2'b11, 0, FMT, 32'h42, 0, FMT, 32'h43, 0, 2'b01, 1, FLT, 32'h41, 1));
        tbl.push_back(mk(0, 2'b11, 0, FLT, 32'h44, 0, FMT, 32'h43, 0, 2'b10, 1, FMT, 32'h42, 1));
        tbl.push_back(mk(0, 2'b00, 0, 0,   0,      0, 0,   0,      0, 2'b00, 1, FMT, 32'h43, 1));
        // invalidate during a stage write forces a reissue
        tbl.push_back(mk(0, 2'b01, 1, FMT, 32'h50, 0, 0,   0,      0, 2'b01, 0, 0,   0,      0));
        tbl.push_back(mk(0, 2'b00, 0, 0,   0,      0, 0,   0,      1, 2'b00, 1, STG, 32'h1,  1));
        tbl.push_back(mk(0, 2'b01, 1, FLT, 32'h51, 0, 0,   0,      0, 2'b01, 1, FMT, 32'h50, 1));
        tbl.push_back(mk(0, 2'b00, 0, 0,   0,      0, 0,   0,      0, 2'b00, 1, STG, 32'h1,  1));
        tbl.push_back(mk(0, 2'b00, 0, 0,   0,      0, 0,   0,      0, 2'b00, 1, FLT, 32'h51, 1));
        tbl.push_back(mk(0, 2'b00, 0, 0,   0,      0, 0,   0,      0, 2'b00, 0, 0,   0,      0));
        // reset while in STAGE drops the held write; shadow and pointer restart
        tbl.push_back(mk(0, 2'b01, 0, FMT, 32'h60, 0, 0,   0,      0, 2'b01, 0, 0,   0,      0));
        tbl.push_back(mk(1, 2'b00, 0, 0,   0,      0, 0,   0,      0, 2'b00, 1, STG, 32'h0,  1));
        tbl.push_back(mk(0, 2'b11, 0, FMT, 32'h61, 0, FLT, 32'h62, 0, 2'b00, 0, 0,   0,      0));
        tbl.push_back(mk(0, 2'b11, 0, FMT, 32'h61, 0, FLT, 32'h62, 0, 2'b01, 0, 0,   0,      0));
        tbl.push_back(mk(0, 2'b10, 0, 0,   0,      0, FLT, 32'h62, 0, 2'b00, 1, STG, 32'h0,  1));
        tbl.push_back(mk(0, 2'b10, 0, 0,   0,      0, FLT, 32'h62, 0, 2'b10, 1, FMT, 32'h61, 1));
        tbl.push_back(mk(0, 2'b00, 0, 0,   0,      0, 0,   0,      0, 2'b00, 1, FLT, 32'h62, 1));
        tbl.push_back(mk(0, 2'b00, 0, 0,   0,      0, 0,   0,      0, 2'b00, 0, 0,   0,      0));

        foreach (tbl[i]) begin
            string tag;
            @(negedge clk);
            reset        = tbl[i].rst;
            req_valid    = tbl[i].v;
            req_stage[0] = tbl[i].s0;
            req_addr[0]  = tbl[i].a0;
            req_data[0]  = tbl[i].d0;
            req_stage[1] = tbl[i].s1;
            req_addr[1]  = tbl[i].a1;
            req_data[1]  = tbl[i].d1;
            invalidate   = tbl[i].inv;
            #1;
            tag = $sformatf("vec%0d", i);
            chk({tag, " req_ready"}, 32'(req_ready), 32'(tbl[i].rdy));
            check_bus(tag, tbl[i].wv, tbl[i].wa, tbl[i].wd);
            chk({tag, " busy"}, 32'(busy), 32'(tbl[i].bsy));
        end

        // shadow is now stage 0 and the pointer favours requester 0
        send(1, 1'b1, FMT, 32'h70, 1'b1, "seq_r1_miss");
        send(1, 1'b1, FLT, 32'h71, 1'b0, "seq_r1_hit");
        send(0, 1'b0, FLT, 32'h72, 1'b1, "seq_r0_miss");

        @(negedge clk);
        #1;
        check_bus("final idle", 1'b0, 12'h0, 32'h0);
        chk("final busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
